// File: rtl/instr_fetch.sv
// instr_fetch: instruction memory plus IDLE/READ/LATCH fetch FSM feeding IR.
// Optional IF_PARITY_EN stores an even-parity bit per word and flags mismatches.
module instr_fetch #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 128
) (
  input  logic              Clk,
  input  logic              ClrN,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              Req,
  input  logic              Flush,
  input  logic              ProgWe,
  input  logic [ADDR_W-1:0] ProgAddr,
  input  logic [DATA_W-1:0] ProgData,
  output logic [DATA_W-1:0] IR,
  output logic              Ack,
  output logic              PcUp,
  output logic              Busy,
  output logic              ParErr
);

`ifdef IF_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    IDLE,
    READ,
    LATCH
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_reg;
  logic [MEM_W-1:0]  rd_data;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  mem [DEPTH];
  logic              cap_en;
  logic              rd_en;
  logic              ld_en;
  logic              par_bad;

  always_ff @(posedge Clk or negedge ClrN) begin
    if (!ClrN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (Req) state_nxt = READ;
      READ:    state_nxt = LATCH;
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (Flush) state_nxt = IDLE;
  end

  always_comb begin
    Busy   = (state != IDLE);
    cap_en = (state == IDLE) && Req && !Flush;
    rd_en  = (state == READ);
    ld_en  = (state == LATCH) && !Flush;
  end

`ifdef IF_PARITY_EN
  assign wr_word = {^ProgData, ProgData};
  // data plus stored even-parity bit must XOR to zero
  assign par_bad = ^rd_data;
`else
  assign wr_word = ProgData;
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (ProgWe) mem[ProgAddr] <= wr_word;
  end

  always_ff @(posedge Clk or negedge ClrN) begin
    if (!ClrN) begin
      addr_reg <= '0;
      rd_data  <= '0;
      IR       <= '0;
      Ack      <= 1'b0;
      PcUp     <= 1'b0;
      ParErr   <= 1'b0;
    end else begin
      Ack    <= ld_en;
      PcUp   <= ld_en;
      ParErr <= ld_en & par_bad;
      if (cap_en) addr_reg <= Addr;
      if (rd_en)  rd_data  <= mem[addr_reg];
      if (ld_en)  IR       <= rd_data[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table vectors plus hand sequences, IR checked via scoreboard.
// Build with +define+IF_PARITY_EN to exercise the parity path.
module tb_instr_fetch;
  logic        Clk = 1'b0;
  logic        ClrN = 1'b0;
  logic        Req = 1'b0;
  logic        Flush = 1'b0;
  logic        ProgWe = 1'b0;
  logic [6:0]  ProgAddr = '0;
  logic [15:0] ProgData = '0;
  logic [6:0]  Addr;
  logic [15:0] IR;
  logic        Ack, PcUp, Busy, ParErr;

  logic [6:0]  addr_drv = '0;
  logic [6:0]  pc = '0;
  logic        pc_en = 1'b0;
  logic        pc_ld = 1'b0;
  logic        par_exp = 1'b0;
  logic        prev_ack = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          acks = 0;
  int          cyc = 0;
  int          a0;
  logic [15:0] expq[$];
  int          ack_cyc[$];

  typedef struct {
    logic [6:0]  a;
    logic [15:0] d;
  } vec_t;
  vec_t tv[6];

  instr_fetch dut (
    .Clk(Clk), .ClrN(ClrN), .Addr(Addr), .Req(Req), .Flush(Flush),
    .ProgWe(ProgWe), .ProgAddr(ProgAddr), .ProgData(ProgData),
    .IR(IR), .Ack(Ack), .PcUp(PcUp), .Busy(Busy), .ParErr(ParErr)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  // PC model: presents the incremented address while Up is asserted
  always @(posedge Clk) begin
    if (pc_ld) pc <= '0;
    else if (PcUp) pc <= pc + 7'd1;
  end
  assign Addr = pc_en ? pc + {6'd0, PcUp} : addr_drv;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (!ClrN) prev_ack = 1'b0;
    else begin
      if (Ack || PcUp) chk("pcup_eq_ack", PcUp, Ack);
      if (!Ack && ParErr) chk("parerr_align", ParErr, 0);
      if (Ack) begin
        acks++;
        ack_cyc.push_back(cyc);
        chk("ack_width", prev_ack, 0);
        chk("parerr", ParErr, par_exp);
        if (expq.size() == 0) chk("unexpected_ack", Ack, 0);
        else chk("ir", IR, expq.pop_front());
      end
      prev_ack = Ack;
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input logic [6:0] a, input logic [15:0] d);
    ProgAddr = a;
    ProgData = d;
    ProgWe = 1'b1;
    step();
    ProgWe = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 12 && expq.size() != 0; i++) begin
      @(negedge Clk);
      #1;
    end
    if (expq.size() != 0) begin
      chk("drain_timeout", expq.size(), 0);
      expq.delete();
    end
  endtask

  task automatic fetch(input logic [6:0] a, input logic [15:0] e);
    addr_drv = a;
    Req = 1'b1;
    expq.push_back(e);
    step();
    Req = 1'b0;
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{7'd0,   16'h0001};
    tv[1] = '{7'd1,   16'hFFFF};
    tv[2] = '{7'd64,  16'h8000};
    tv[3] = '{7'd127, 16'h7E5A};
    tv[4] = '{7'd42,  16'h0000};
    tv[5] = '{7'd85,  16'hC3A5};

    repeat (3) step();
    chk("rst_ir", IR, 16'h0);
    chk("rst_ack", Ack, 0);
    chk("rst_pcup", PcUp, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_parerr", ParErr, 0);
    ClrN = 1'b1;
    step();

    foreach (tv[i]) load(tv[i].a, tv[i].d);
    foreach (tv[i]) fetch(tv[i].a, tv[i].d);

    load(7'd3, 16'hA5C3);
    step();
    addr_drv = 7'd3;
    Req = 1'b1;
    expq.push_back(16'hA5C3);
    step();
    Req = 1'b0;
    chk("e0_busy", Busy, 1);
    chk("e0_ack", Ack, 0);
    step();
    chk("e1_busy", Busy, 1);
    chk("e1_ack", Ack, 0);
    step();
    chk("e2_ack", Ack, 1);
    chk("e2_pcup", PcUp, 1);
    chk("e2_ir", IR, 16'hA5C3);
    chk("e2_busy", Busy, 0);
    step();
    chk("e3_ack", Ack, 0);
    chk("e3_pcup", PcUp, 0);

    for (int k = 0; k < 4; k++) load(7'(k), 16'h0100 + 16'(k));
    pc_ld = 1'b1;
    step();
    pc_ld = 1'b0;
    pc_en = 1'b1;
    a0 = acks;
    ack_cyc.delete();
    for (int k = 0; k < 4; k++) expq.push_back(16'h0100 + 16'(k));
    Req = 1'b1;
    repeat (10) step();
    Req = 1'b0;
    repeat (6) step();
    chk("stream_count", acks - a0, 4);
    for (int i = 1; i < 4; i++)
      chk("stream_gap", ack_cyc[i] - ack_cyc[i-1], 3);
    chk("stream_pc", pc, 7'd4);
    pc_en = 1'b0;
    wait_drain();

    load(7'd9, 16'hBEEF);
    a0 = acks;
    addr_drv = 7'd9;
    Req = 1'b1;
    step();
    Req = 1'b0;
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    chk("flush_read_busy", Busy, 0);
    repeat (4) step();
    chk("flush_read_ir", IR, 16'h0103);
    chk("flush_read_acks", acks - a0, 0);
    Req = 1'b1;
    step();
    Req = 1'b0;
    step();
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    repeat (3) step();
    chk("flush_latch_ir", IR, 16'h0103);
    chk("flush_latch_acks", acks - a0, 0);
    Req = 1'b1;
    Flush = 1'b1;
    step();
    chk("flush_req_busy", Busy, 0);
    Req = 1'b0;
    Flush = 1'b0;
    repeat (3) step();
    chk("flush_req_acks", acks - a0, 0);
    fetch(7'd9, 16'hBEEF);

    load(7'd127, 16'h1111);
    addr_drv = 7'd127;
    Req = 1'b1;
    expq.push_back(16'h1111);
    step();
    Req = 1'b0;
    ProgAddr = 7'd127;
    ProgData = 16'h2222;
    ProgWe = 1'b1;
    step();
    ProgWe = 1'b0;
    wait_drain();
    fetch(7'd127, 16'h2222);

    load(7'd5, 16'h1234);
    addr_drv = 7'd5;
    Req = 1'b1;
    step();
    Req = 1'b0;
    #2;
    ClrN = 1'b0;
    #1;
    chk("midrst_ir", IR, 16'h0);
    chk("midrst_ack", Ack, 0);
    chk("midrst_busy", Busy, 0);
    #2;
    ClrN = 1'b1;
    a0 = acks;
    repeat (5) step();
    chk("midrst_no_ack", acks - a0, 0);
    load(7'd5, 16'h1234);
    fetch(7'd5, 16'h1234);

`ifdef IF_PARITY_EN
    load(7'd20, 16'h0F0F);
    dut.mem[20][0] = ~dut.mem[20][0];
    par_exp = 1'b1;
    fetch(7'd20, 16'h0F0E);
    par_exp = 1'b0;
    load(7'd21, 16'h0F0F);
    fetch(7'd21, 16'h0F0F);
`else
    load(7'd20, 16'h0F0F);
    fetch(7'd20, 16'h0F0F);
`endif

    repeat (3) step();
    chk("final_queue", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
